piton_core_reset_ctrl: RTL and testbench

Per-tile core reset and interrupt conditioning block that sits between the OpenPiton tile and the core.
- Generalises the fixed 16-bit wake-up counter into a parametrised wake sequencer with selectable wake source (counter, L15 wake interrupt, or both).
- Adds a software soft-reset sequence and a configurable-depth synchronizer bank for N interrupt lines.
- Gates all interrupt outputs until the core is out of reset.

---
 rtl/piton_rst_pkg.sv | 22 ++
 rtl/sync_chain.sv | 21 ++
 rtl/piton_core_reset_ctrl.sv | 118 +++++++++++
 tb/tb_piton_core_reset_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/piton_rst_pkg.sv
// piton_rst_pkg: shared types and configuration checks for the core reset controller
package piton_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WAKE_CNT  = 2'd0,
        WAKE_PKT  = 2'd1,
        WAKE_BOTH = 2'd2
    } wake_mode_e;

    // The hold must outlast the reset synchronizer so the core sees reset drop.
    function automatic bit soft_rst_cycles_ok(input int unsigned cycles, input int unsigned stages);
        return cycles >= stages + 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: single-bit multi-flop synchronizer with asynchronous active-low clear
module sync_chain #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] ff_q;

    // shift the input through the chain; reset clears every stage at once
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) ff_q <= '0;
        else          ff_q <= {ff_q[Stages-2:0], d};
    end

    assign q = ff_q[Stages-1];

endmodule

// File: rtl/piton_core_reset_ctrl.sv
// piton_core_reset_ctrl: tile-to-core wake sequencing, soft reset and interrupt conditioning
module piton_core_reset_ctrl
    import piton_rst_pkg::*;
#(
    parameter int unsigned WakeCntWidth  = 16,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned NrIrq         = 2,
    parameter int unsigned WakeMode      = 0,
    parameter bit          SoftRstEn     = 1'b1,
    parameter int unsigned SoftRstCycles = 8
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             wake_pkt_i,
    input  logic             sw_rst_req_i,
    input  logic [NrIrq-1:0] irq_i,
    input  logic             ipi_i,
    input  logic             time_irq_i,
    input  logic             debug_req_i,
    output logic             spc_grst_l,
    output logic [NrIrq-1:0] irq_o,
    output logic             ipi_o,
    output logic             time_irq_o,
    output logic             debug_req_o,
    output logic [1:0]       state_o
);

    localparam int unsigned      HoldW    = $clog2(SoftRstCycles + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(SoftRstCycles - 1);
    localparam wake_mode_e       Mode     = wake_mode_e'(WakeMode[1:0]);
    localparam int unsigned      NrIn     = NrIrq + 3;

    if (!soft_rst_cycles_ok(SoftRstCycles, SyncStages)) begin : g_cfg_err
        $error("SoftRstCycles must be at least SyncStages+1");
    end

    state_e                  state_q, state_d;
    logic [WakeCntWidth-1:0] cnt_q, cnt_d;
    logic                    wake_seen_q, wake_seen_d;
    logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                    cnt_msb, wake_ok, rst_req, run;
    logic [NrIn-1:0]         int_async, int_sync;

    assign cnt_msb = cnt_q[WakeCntWidth-1];
    assign wake_ok = (Mode == WAKE_CNT) ? cnt_msb :
                     (Mode == WAKE_PKT) ? wake_seen_q : (cnt_msb & wake_seen_q);
    assign rst_req = (state_q == ST_RELEASE) || (state_q == ST_RUN);
    assign run     = (state_q == ST_RUN);

    // sequencer state registers, all cleared by the chip reset
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            wake_seen_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wake_seen_q <= wake_seen_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // next-state: wake counting and packet capture only happen in WAIT
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wake_seen_d = wake_seen_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d       = cnt_msb ? cnt_q : cnt_q + 1'b1;
                wake_seen_d = wake_seen_q | wake_pkt_i;
                if (wake_ok) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (spc_grst_l) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (SoftRstEn && sw_rst_req_i) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HoldLast) state_d = ST_RELEASE;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    sync_chain #(.Stages(SyncStages)) u_rst_sync (
        .clk_i   (clk_i),
        .reset_l (reset_l),
        .d       (rst_req),
        .q       (spc_grst_l)
    );

    assign int_async = {debug_req_i, time_irq_i, ipi_i, irq_i};

    for (genvar i = 0; i < NrIn; i++) begin : g_int_sync
        sync_chain #(.Stages(SyncStages)) u_sync (
            .clk_i   (clk_i),
            .reset_l (reset_l),
            .d       (int_async[i]),
            .q       (int_sync[i])
        );
    end

    assign irq_o       = int_sync[NrIrq-1:0] & {NrIrq{run}};
    assign ipi_o       = int_sync[NrIrq]     & run;
    assign time_irq_o  = int_sync[NrIrq+1]   & run;
    assign debug_req_o = int_sync[NrIrq+2]   & run;
    assign state_o     = state_q;

endmodule

// File: tb/tb_piton_core_reset_ctrl.sv
// tb_piton_core_reset_ctrl: directed checks of three wake-mode variants driven in lockstep
module tb_piton_core_reset_ctrl;

    logic       clk_i, reset_l, wake_pkt_i, sw_rst_req_i, ipi_i, time_irq_i, debug_req_i;
    logic [1:0] irq_i;
    logic       grst [3];
    logic [1:0] irq  [3];
    logic       ipi  [3];
    logic       tim  [3];
    logic       dbg  [3];
    logic [1:0] st   [3];
    logic [1:0] es   [3];
    logic       eg   [3];
    logic [1:0] ei;
    logic       eo;
    int         errors = 0;
    int         checks = 0;

    // index 0: counter wake, width 4; 1: packet wake, width 16; 2: both, width 4
    piton_core_reset_ctrl #(.WakeCntWidth(4), .WakeMode(0)) u_cnt (
        .clk_i(clk_i), .reset_l(reset_l), .wake_pkt_i(wake_pkt_i), .sw_rst_req_i(sw_rst_req_i),
        .irq_i(irq_i), .ipi_i(ipi_i), .time_irq_i(time_irq_i), .debug_req_i(debug_req_i),
        .spc_grst_l(grst[0]), .irq_o(irq[0]), .ipi_o(ipi[0]), .time_irq_o(tim[0]),
        .debug_req_o(dbg[0]), .state_o(st[0]));

    piton_core_reset_ctrl #(.WakeCntWidth(16), .WakeMode(1)) u_pkt (
        .clk_i(clk_i), .reset_l(reset_l), .wake_pkt_i(wake_pkt_i), .sw_rst_req_i(sw_rst_req_i),
        .irq_i(irq_i), .ipi_i(ipi_i), .time_irq_i(time_irq_i), .debug_req_i(debug_req_i),
        .spc_grst_l(grst[1]), .irq_o(irq[1]), .ipi_o(ipi[1]), .time_irq_o(tim[1]),
        .debug_req_o(dbg[1]), .state_o(st[1]));

    piton_core_reset_ctrl #(.WakeCntWidth(4), .WakeMode(2)) u_both (
        .clk_i(clk_i), .reset_l(reset_l), .wake_pkt_i(wake_pkt_i), .sw_rst_req_i(sw_rst_req_i),
        .irq_i(irq_i), .ipi_i(ipi_i), .time_irq_i(time_irq_i), .debug_req_i(debug_req_i),
        .spc_grst_l(grst[2]), .irq_o(irq[2]), .ipi_o(ipi[2]), .time_irq_o(tim[2]),
        .debug_req_o(dbg[2]), .state_o(st[2]));

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; wake_pkt_i = 1'b0; sw_rst_req_i = 1'b0;
        irq_i = 2'b11; ipi_i = 1'b0; time_irq_i = 1'b0; debug_req_i = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (st[d] !== 2'd0 || grst[d] !== 1'b0 || irq[d] !== 2'b00 || dbg[d] !== 1'b0 ||
                ipi[d] !== 1'b0 || tim[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: state=%0d grst=%b irq=%b dbg=%b ipi=%b tim=%b, want all 0",
                         d, st[d], grst[d], irq[d], dbg[d], ipi[d], tim[d]);
            end
        end
        @(posedge clk_i);
        #3 reset_l = 1'b1;
    endtask

    // irq and debug held high through WAIT; packet sampled at edge 3
    task automatic test_wake();
        for (int e = 1; e <= 13; e++) begin
            wake_pkt_i = (e == 3);
            tick();
            es[0] = e >= 12 ? 2'd2 : e >= 9 ? 2'd1 : 2'd0;
            es[2] = es[0];
            es[1] = e >= 7 ? 2'd2 : e >= 4 ? 2'd1 : 2'd0;
            eg[0] = e >= 11; eg[2] = eg[0]; eg[1] = e >= 6;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (st[d] !== es[d] || grst[d] !== eg[d]) begin
                    errors++;
                    $display("FAIL wake dut%0d edge%0d: state=%0d grst=%b, want state=%0d grst=%b",
                             d, e, st[d], grst[d], es[d], eg[d]);
                end
                ei = es[d] == 2'd2 ? 2'b11 : 2'b00;
                checks++;
                if (irq[d] !== ei || dbg[d] !== ei[0] || ipi[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL wake_gate dut%0d edge%0d: irq=%b dbg=%b ipi=%b, want irq=%b dbg=%b ipi=0",
                             d, e, irq[d], dbg[d], ipi[d], ei, ei[0]);
                end
            end
        end
        wake_pkt_i = 1'b0;
    endtask

    // all three in RUN; interrupt latency, then soft reset with hold of 8
    task automatic test_irq_soft_rst();
        irq_i = 2'b00; debug_req_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin irq_i = 2'b10; ipi_i = 1'b1; time_irq_i = 1'b1; end
            tick();
            ei = k == 0 ? 2'b11 : k == 3 ? 2'b10 : 2'b00;
            eo = k == 3;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (irq[d] !== ei || dbg[d] !== (k == 0) || ipi[d] !== eo || tim[d] !== eo) begin
                    errors++;
                    $display("FAIL irq_lat dut%0d step%0d: irq=%b dbg=%b ipi=%b tim=%b, want irq=%b dbg=%b ipi=%b tim=%b",
                             d, k, irq[d], dbg[d], ipi[d], tim[d], ei, k == 0, eo, eo);
                end
            end
        end
        sw_rst_req_i = 1'b1;
        for (int h = 0; h <= 12; h++) begin
            tick();
            sw_rst_req_i = (h == 10);
            es[0] = h < 8 ? 2'd3 : h < 11 ? 2'd1 : 2'd2;
            eg[0] = h < 2 || h >= 10;
            ei = es[0] == 2'd2 ? 2'b10 : 2'b00;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (st[d] !== es[0] || grst[d] !== eg[0] || irq[d] !== ei || ipi[d] !== ei[1]) begin
                    errors++;
                    $display("FAIL soft_rst dut%0d F+%0d: state=%0d grst=%b irq=%b ipi=%b, want state=%0d grst=%b irq=%b ipi=%b",
                             d, h, st[d], grst[d], irq[d], ipi[d], es[0], eg[0], ei, ei[1]);
                end
            end
        end
        sw_rst_req_i = 1'b0;
    endtask

    task automatic test_async_reset();
        #3 reset_l = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (st[d] !== 2'd0 || grst[d] !== 1'b0 || irq[d] !== 2'b00 || ipi[d] !== 1'b0 || tim[d] !== 1'b0) begin
                errors++;
                $display("FAIL async_run dut%0d: state=%0d grst=%b irq=%b ipi=%b tim=%b, want all 0",
                         d, st[d], grst[d], irq[d], ipi[d], tim[d]);
            end
        end
        reset_l = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            sw_rst_req_i = (e == 13);
            tick();
            es[0] = e == 13 ? 2'd3 : e >= 12 ? 2'd2 : e >= 9 ? 2'd1 : 2'd0;
            ei = es[0] == 2'd2 ? 2'b10 : 2'b00;
            checks++;
            if (st[0] !== es[0] || irq[0] !== ei || st[1] !== 2'd0 || st[2] !== 2'd0) begin
                errors++;
                $display("FAIL restart edge%0d: state=%0d/%0d/%0d irq=%b, want state=%0d/0/0 irq=%b",
                         e, st[0], st[1], st[2], irq[0], es[0], ei);
            end
        end
        sw_rst_req_i = 1'b0;
        tick();
        tick();
        #3 reset_l = 1'b0;
        #1;
        checks++;
        if (st[0] !== 2'd0 || grst[0] !== 1'b0 || irq[0] !== 2'b00 || ipi[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_hold: state=%0d grst=%b irq=%b ipi=%b, want all 0", st[0], grst[0], irq[0], ipi[0]);
        end
        reset_l = 1'b1;
    endtask

    // packet arriving after the counter MSB in mode 2
    task automatic test_late_pkt();
        for (int e = 1; e <= 11; e++) begin
            wake_pkt_i = (e == 10);
            tick();
            es[0] = e >= 9 ? 2'd1 : 2'd0;
            es[1] = e >= 11 ? 2'd1 : 2'd0;
            es[2] = es[1];
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (st[d] !== es[d]) begin
                    errors++;
                    $display("FAIL late_pkt dut%0d edge%0d: state=%0d, want %0d", d, e, st[d], es[d]);
                end
            end
        end
        wake_pkt_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wake();
        test_irq_soft_rst();
        test_async_reset();
        test_late_pkt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
